control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the program/data memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, the accumulator, instruction and memory word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; reset is synchronous and active-high.
REQ-005 mem_req  output  1  memory transaction request.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  ADDR_W  transaction address.
REQ-008 mem_wdata  output  DATA_W  write data (accumulator).
REQ-009 mem_rdata  input  DATA_W  read data; valid in the mem_ack cycle.
REQ-010 mem_ack  input  1  transaction complete; ignored while mem_req=0.
REQ-011 acc_data  output  DATA_W  accumulator to ALU.
REQ-012 mem_data  output  DATA_W  latched operand register to ALU.
REQ-013 arg_data  output  DATA_W  instruction argument, zero-extended.
REQ-014 ctl_nad, ctl_shr, ctl_shl, ctl_arg  output  1 each  ALU op selects.
REQ-015 result  input  DATA_W  ALU result.
REQ-016 is_zero  input  1  ALU accumulator-zero flag.
REQ-017 halted  output  1  high while in HALT.

Function
REQ-018 Instruction format SHALL be opcode = ir[15:12], arg = ir[11:0].
REQ-019 Opcodes SHALL be: 0 NOP, 1 LDI, 2 NAD, 3 SHR, 4 SHL, 5 STA, 6 JMP, 7 JZ, F HLT; opcodes 8-E SHALL execute as NOP.
REQ-020 States SHALL be FETCH, DECODE, LOAD, EXEC, STORE, HALT.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack: ir<=mem_rdata, pc<=pc+1 modulo 2^ADDR_W (4095 wraps to 0), next state DECODE.
REQ-022 DECODE (1 cycle): NAD->LOAD; LDI/SHR/SHL->EXEC; STA->STORE; JMP: pc<=arg, ->FETCH; JZ: pc<=arg if is_zero=1, ->FETCH; HLT->HALT; NOP->FETCH.
REQ-023 LOAD: mem_req=1, mem_we=0, mem_addr=arg; on mem_ack: operand<=mem_rdata, ->EXEC.
REQ-024 EXEC (1 cycle): exactly one ctl_* high (LDI->ctl_arg, NAD->ctl_nad, SHR->ctl_shr, SHL->ctl_shl); acc<=result at cycle end; ->FETCH.
REQ-025 STORE: mem_req=1, mem_we=1, mem_addr=arg, mem_wdata=acc; on mem_ack ->FETCH.
REQ-026 All ctl_* SHALL be 0 outside EXEC.
REQ-027 mem_req, mem_we, mem_addr, mem_wdata SHALL be held stable from assertion until the mem_ack cycle inclusive; mem_req SHALL drop in the cycle after ack.
REQ-028 mem_ack arriving in the same cycle mem_req first rises SHALL complete the transaction (zero-wait memory).
REQ-029 HALT: mem_req=0, halted=1, state held until rst.
REQ-030 JZ SHALL use is_zero as sampled in DECODE (reflecting current acc).
REQ-031 Cycle counts with zero-wait memory: NOP/JMP/JZ 2, LDI/SHR/SHL/STA 3, NAD 4.

Reset
REQ-032 With rst=1 at a rising edge: pc=0, acc=0, ir=0, operand=0, state=FETCH; during the rst cycle mem_req=0, ctl_*=0, halted=0.
REQ-033 rst during any state, including mid-transaction, SHALL abort without completing any write or acc update; the first fetch from address 0 SHALL request in the first cycle after rst falls.

Structure
REQ-034 Opcode enum, state enum, ADDR_W/DATA_W defaults and field positions SHALL live in shared package small_pkg.
REQ-035 No internal sub-module; alu SHALL be instantiated beside control_unit at the top level.

Verification
REQ-036 LDI 0x123 then HLT, zero-wait memory -> acc=0x0123 after 5 cycles, halted=1, pc=2.
REQ-037 acc=0x00F0, NAD with mem[0x010]=0x0FF0 -> LOAD reads 0x010, acc=0xFF0F.
REQ-038 acc=0x8001: SHL -> 0x0002; then SHR -> 0x0001.
REQ-039 acc=0x0000, JZ 0x020 -> next fetch at 0x020; acc=0x0001, JZ 0x020 -> next fetch at pc+1.
REQ-040 STA 0x030 with acc=0xBEEF, mem_ack delayed 3 cycles -> req/we/addr/wdata stable 4 cycles, memory holds 0xBEEF.
REQ-041 pc=0xFFF, NOP fetched -> pc wraps to 0x000; rst asserted during a STORE wait -> no write, restart at 0x000.

Source files
------------

// File: rtl/small_pkg.sv
// Shared definitions for the accumulator control unit: default widths,
// instruction field positions, opcode and FSM state encodings.
package small_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    // Instruction word layout: opcode in the top nibble, argument below it
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int ARG_MSB = 11;
    localparam int ARG_LSB = 0;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int ARG_W   = ARG_MSB - ARG_LSB + 1;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_NAD = 4'h2,
        OP_SHR = 4'h3,
        OP_SHL = 4'h4,
        OP_STA = 4'h5,
        OP_JMP = 4'h6,
        OP_JZ  = 4'h7,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_EXEC   = 3'd3,
        S_STORE  = 3'd4,
        S_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control unit for a small accumulator machine; the ALU sits
// beside it and is steered through the ctl_* selects.
module control_unit
    import small_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc_data,
    output logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] arg_data,
    output logic              ctl_nad,
    output logic              ctl_shr,
    output logic              ctl_shl,
    output logic              ctl_arg,
    input  logic [DATA_W-1:0] result,
    input  logic              is_zero,
    output logic              halted
);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_operand;
    logic [OPC_W-1:0]  w_op;
    logic [ARG_W-1:0]  w_arg;
    logic [ADDR_W-1:0] w_arg_addr;

    assign w_op       = r_ir[OPC_MSB:OPC_LSB];
    assign w_arg      = r_ir[ARG_MSB:ARG_LSB];
    assign w_arg_addr = ADDR_W'(w_arg);

    assign acc_data  = r_acc;
    assign mem_data  = r_operand;
    assign arg_data  = DATA_W'(w_arg);
    assign mem_wdata = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // mem_ack is only looked at in states that hold mem_req high
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_NAD:                 w_next = S_LOAD;
                    OP_LDI, OP_SHR, OP_SHL: w_next = S_EXEC;
                    OP_STA:                 w_next = S_STORE;
                    OP_HLT:                 w_next = S_HALT;
                    default:                w_next = S_FETCH;
                endcase
            end
            S_LOAD: begin
                if (mem_ack) w_next = S_EXEC;
            end
            S_EXEC:  w_next = S_FETCH;
            S_STORE: begin
                if (mem_ack) w_next = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs are silenced during the reset cycle so an aborted store never lands
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = r_pc;
        ctl_nad  = 1'b0;
        ctl_shr  = 1'b0;
        ctl_shl  = 1'b0;
        ctl_arg  = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: mem_req = 1'b1;
                S_LOAD: begin
                    mem_req  = 1'b1;
                    mem_addr = w_arg_addr;
                end
                S_STORE: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = w_arg_addr;
                end
                S_EXEC: begin
                    case (w_op)
                        OP_LDI:  ctl_arg = 1'b1;
                        OP_NAD:  ctl_nad = 1'b1;
                        OP_SHR:  ctl_shr = 1'b1;
                        OP_SHL:  ctl_shl = 1'b1;
                        default: ;
                    endcase
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_acc     <= '0;
            r_operand <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                // JZ looks at is_zero here, while the ALU still reflects the current acc
                S_DECODE: begin
                    if (w_op == OP_JMP || (w_op == OP_JZ && is_zero)) begin
                        r_pc <= w_arg_addr;
                    end
                end
                S_LOAD: begin
                    if (mem_ack) r_operand <= mem_rdata;
                end
                S_EXEC:  r_acc <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural ALU and memory around the DUT, with an
// instruction-level model predicting every bus transaction and final state.
module tb_control_unit;
    import small_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] acc_data, mem_data, arg_data, result;
    logic          ctl_nad, ctl_shr, ctl_shl, ctl_arg;
    logic          is_zero, halted;

    control_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .acc_data(acc_data), .mem_data(mem_data), .arg_data(arg_data),
        .ctl_nad(ctl_nad), .ctl_shr(ctl_shr), .ctl_shl(ctl_shl), .ctl_arg(ctl_arg),
        .result(result), .is_zero(is_zero), .halted(halted)
    );

    always #5 clk = ~clk;

    // ALU: NAND with operand, logical shifts by one, load argument
    always_comb begin
        result = acc_data;
        if (ctl_arg)      result = arg_data;
        else if (ctl_nad) result = ~(acc_data & mem_data);
        else if (ctl_shr) result = acc_data >> 1;
        else if (ctl_shl) result = acc_data << 1;
    end
    assign is_zero = (acc_data == '0);

    logic [15:0] mem [0:4095];
    logic [15:0] mm  [0:4095];
    int mem_wait = 0, mem_delay = 0, mem_min = 0, mem_max = 0;
    assign mem_ack   = mem_req && (mem_wait >= mem_delay);
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        bit          fetch;
        bit          we;
        logic [11:0] addr;
        logic [15:0] wdata;
        int          cyc;
    } txn_t;
    txn_t exp_q[$];

    int  n_cmp = 0, n_err = 0;
    int  cyc = 0, last_fetch = -1, held = 0, last_store_held = 0;
    bit  mon_en = 0, zero_wait = 0, in_txn = 0, stable = 0;
    bit  m_halted;
    int  m_acc;
    logic        h_we;
    logic [11:0] h_addr;
    logic [15:0] h_wd;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        txn_t e;
        if (cyc == 0) chk_eq("first_fetch_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 12'h000});
        if (ctl_arg | ctl_nad | ctl_shr | ctl_shl) begin
            chk_eq("ctl_onehot", $countones({ctl_arg, ctl_nad, ctl_shr, ctl_shl}), 1);
            chk_eq("ctl_no_req", mem_req, 0);
        end
        if (mem_req) begin
            if (!in_txn) begin
                in_txn = 1; stable = 1; held = 0;
                h_we = mem_we; h_addr = mem_addr; h_wd = mem_wdata;
            end else if (mem_we !== h_we || mem_addr !== h_addr || mem_wdata !== h_wd) begin
                stable = 0;
            end
            held++;
            if (mem_ack) begin
                chk_eq("bus_stable", stable, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk_eq("txn_we", mem_we, e.we);
                    chk_eq("txn_addr", mem_addr, e.addr);
                    if (e.we) chk_eq("store_data", mem_wdata, e.wdata);
                    if (e.fetch) begin
                        if (zero_wait && last_fetch >= 0) chk_eq("instr_cycles", cyc - last_fetch, e.cyc);
                        last_fetch = cyc;
                    end
                end
                if (mem_we) last_store_held = held;
                in_txn = 0;
            end
        end else begin
            in_txn = 0;
        end
    endtask

    // One clock: observe at the falling edge, let memory respond just after the rising edge
    task automatic tick();
        logic        do_wr, busy;
        logic [11:0] wa;
        logic [15:0] wd;
        @(negedge clk);
        do_wr = mem_req && mem_we && mem_ack;
        busy  = mem_req && !mem_ack;
        wa = mem_addr; wd = mem_wdata;
        if (rst) begin
            cyc = 0; last_fetch = -1; in_txn = 0;
        end else begin
            if (mon_en) monitor();
            cyc++;
        end
        @(posedge clk); #1;
        if (do_wr) mem[wa] = wd;
        if (busy) mem_wait++;
        else begin
            mem_wait  = 0;
            mem_delay = $urandom_range(mem_max, mem_min);
        end
    endtask

    // Instruction-level model: walks the program and queues every expected transaction
    task automatic build_expect(input int max_instr);
        int pc, op, arg, cycles, prev;
        int ir;
        txn_t t;
        for (int i = 0; i < 4096; i++) mm[i] = mem[i];
        exp_q.delete();
        pc = 0; m_acc = 0; m_halted = 0; prev = 0;
        for (int n = 0; n < max_instr && !m_halted; n++) begin
            t.fetch = 1; t.we = 0; t.addr = pc[11:0]; t.wdata = 0; t.cyc = prev;
            exp_q.push_back(t);
            ir = int'(mm[pc]);
            pc = (pc + 1) % 4096;
            op = ir / 4096;
            arg = ir % 4096;
            cycles = 2;
            case (op)
                1: begin m_acc = arg; cycles = 3; end
                2: begin
                    t.fetch = 0; t.we = 0; t.addr = arg[11:0]; t.wdata = 0; t.cyc = 0;
                    exp_q.push_back(t);
                    m_acc = (~(m_acc & int'(mm[arg]))) & 16'hFFFF;
                    cycles = 4;
                end
                3: begin m_acc = m_acc / 2; cycles = 3; end
                4: begin m_acc = (m_acc * 2) % 65536; cycles = 3; end
                5: begin
                    t.fetch = 0; t.we = 1; t.addr = arg[11:0]; t.wdata = m_acc[15:0]; t.cyc = 0;
                    exp_q.push_back(t);
                    mm[arg] = m_acc[15:0];
                    cycles = 3;
                end
                6: pc = arg;
                7: if (m_acc == 0) pc = arg;
                15: m_halted = 1;
                default: ;
            endcase
            prev = cycles;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic run_prog(input bit zw, input int mn, input int mx, input int max_instr);
        int n;
        zero_wait = zw; mem_min = mn; mem_max = mx;
        build_expect(max_instr);
        mon_en = 1;
        rst = 1;
        tick(); tick();
        rst = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            tick();
            n++;
        end
        chk_eq("txn_drain", exp_q.size(), 0);
        if (m_halted) begin
            tick(); tick(); tick();
            chk_eq("halted", halted, 1);
            chk_eq("halt_no_req", mem_req, 0);
            chk_eq("final_acc", acc_data, m_acc);
        end
    endtask

    task automatic load_sta_prog();
        clear_mem();
        mem[12'h000] = 16'h2100;
        mem[12'h001] = 16'h2101;
        mem[12'h002] = 16'h5030;
        mem[12'h003] = 16'hF000;
        mem[12'h100] = 16'h1234;
        mem[12'h101] = 16'h4110;
    endtask

    initial begin
        int n, op, arg;

        clear_mem();
        rst = 1;
        tick(); tick();
        chk_eq("por_acc", acc_data, 0);
        chk_eq("por_req", mem_req, 0);
        chk_eq("por_halted", halted, 0);

        // LDI 0x123 ; HLT
        clear_mem();
        mem[0] = 16'h1123;
        mem[1] = 16'hF000;
        run_prog(1, 0, 0, 10);
        chk_eq("ldi_acc", acc_data, 16'h0123);

        // NAD, then shifts of 0x8001, with results stored for inspection
        clear_mem();
        mem[0]  = 16'h10F0; mem[1]  = 16'h2010; mem[2]  = 16'h5040;
        mem[3]  = 16'h1000; mem[4]  = 16'h2011; mem[5]  = 16'h2012;
        mem[6]  = 16'h5041; mem[7]  = 16'h4000; mem[8]  = 16'h5042;
        mem[9]  = 16'h3000; mem[10] = 16'h5043; mem[11] = 16'hF000;
        mem[12'h010] = 16'h0FF0; mem[12'h011] = 16'h1234; mem[12'h012] = 16'h7FFE;
        run_prog(1, 0, 0, 20);
        chk_eq("nad_result", mem[12'h040], 16'hFF0F);
        chk_eq("nad_8001", mem[12'h041], 16'h8001);
        chk_eq("shl_result", mem[12'h042], 16'h0002);
        chk_eq("shr_result", mem[12'h043], 16'h0001);

        // Reset from a halted machine with live registers
        rst = 1;
        tick();
        chk_eq("rst_acc", acc_data, 0);
        chk_eq("rst_operand", mem_data, 0);
        chk_eq("rst_arg", arg_data, 0);
        chk_eq("rst_halted", halted, 0);
        chk_eq("rst_req", mem_req, 0);

        // JZ taken to 0xFFE, run off the top of memory, JZ not taken
        clear_mem();
        mem[12'h000] = 16'h7FFE;
        mem[12'h001] = 16'hF000;
        mem[12'hFFE] = 16'h1001;
        mem[12'hFFF] = 16'h0000;
        run_prog(1, 0, 0, 10);
        chk_eq("jz_acc", acc_data, 16'h0001);

        // Store of 0xBEEF with a three-cycle memory
        load_sta_prog();
        run_prog(0, 3, 3, 10);
        chk_eq("sta_mem", mem[12'h030], 16'hBEEF);
        chk_eq("sta_held", last_store_held, 4);

        // Reset while the store is waiting for its acknowledge
        load_sta_prog();
        mon_en = 0; mem_min = 3; mem_max = 3;
        rst = 1;
        tick(); tick();
        rst = 0;
        n = 0;
        while (!(mem_req && mem_we) && n < 100) begin
            tick();
            n++;
        end
        chk_eq("store_seen", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 12'h030});
        rst = 1; #1;
        chk_eq("rst_gates_req", mem_req, 0);
        tick();
        chk_eq("no_write_on_rst", mem[12'h030], 16'h0000);
        chk_eq("rst_abort_acc", acc_data, 0);
        rst = 0; #1;
        chk_eq("restart_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 12'h000});

        // Random programs, first with zero-wait memory then with random latency
        for (int r = 0; r < 6; r++) begin
            clear_mem();
            for (int a = 0; a < 64; a++) begin
                op = $urandom_range(15, 0);
                if (op == 15 && $urandom_range(3, 0) != 0) op = 1;
                if (op == 2 || op == 5)      arg = 12'h100 + $urandom_range(15, 0);
                else if (op == 6 || op == 7) arg = $urandom_range(63, 0);
                else                         arg = $urandom_range(4095, 0);
                mem[a] = 16'(op * 4096 + arg);
            end
            mem[64] = 16'hF000;
            for (int d = 0; d < 16; d++) mem[12'h100 + d] = 16'($urandom);
            run_prog(r < 3, 0, (r < 3) ? 0 : 3, 300);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
